// File: rtl/timebase_pkg.sv
// Shared widths, types and the duty-cycle high-count helper for the cascaded timebase.
package timebase_pkg;

    localparam int unsigned DUTY_W        = 8;
    localparam int unsigned CNT_WIDTH_DEF = 28;
    localparam int unsigned HC_W          = 32;
    localparam int unsigned PROD_W        = HC_W + DUTY_W;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

    // Cycles per period that Level stays high: (div*duty)/100, kept inside 1..div-1.
    function automatic logic [HC_W-1:0] high_count(input logic [HC_W-1:0]   div,
                                                   input logic [DUTY_W-1:0] duty);
        logic [PROD_W-1:0] div_w;
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] quot;
        logic [HC_W-1:0]   res;
        div_w = PROD_W'(div);
        prod  = div_w * PROD_W'(duty);
        quot  = prod / PROD_W'(100);
        if (div < HC_W'(2)) begin
            res = HC_W'(1);
        end else if (quot == '0) begin
            res = HC_W'(1);
        end else if (quot > div_w - PROD_W'(1)) begin
            res = div - HC_W'(1);
        end else begin
            res = HC_W'(quot);
        end
        return res;
    endfunction

endpackage

// File: rtl/timebase_stage.sv
// One divider stage: counter, active/shadow divisor with deferred apply, Tick and Level registers.
module timebase_stage
    import timebase_pkg::*;
#(
    parameter int unsigned           CNT_WIDTH = CNT_WIDTH_DEF,
    parameter logic [CNT_WIDTH-1:0]  RESET_DIV = CNT_WIDTH'(1),
    parameter logic [DUTY_W-1:0]     DUTY      = DUTY_W'(50)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 in_tick,
    input  logic                 restart,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 wrap_c,
    output logic                 tick,
    output logic                 level,
    output logic                 pending
);

    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RESET_HIGH = CNT_WIDTH'(high_count(HC_W'(RESET_DIV), DUTY));

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] div_next;
    logic [CNT_WIDTH-1:0] high;
    logic [CNT_WIDTH-1:0] high_next;
    logic [CNT_WIDTH-1:0] shadow;
    logic [CNT_WIDTH-1:0] shadow_next;
    logic                 pending_next;
    logic                 apply_c;

    // A pending divisor takes effect only at a period boundary (wrap) or on restart.
    always_comb begin
        wrap_c       = in_tick && (cnt == div - ONE);
        apply_c      = pending && (wrap_c || restart);
        div_next     = div;
        high_next    = high;
        cnt_next     = cnt;
        shadow_next  = shadow;
        pending_next = pending;
        if (apply_c) begin
            div_next  = shadow;
            high_next = CNT_WIDTH'(high_count(HC_W'(shadow), DUTY));
        end
        if (restart || wrap_c) begin
            cnt_next = '0;
        end else if (in_tick) begin
            cnt_next = cnt + ONE;
        end
        // A load landing on the apply edge re-arms pending for the following wrap.
        if (load) begin
            shadow_next  = load_value;
            pending_next = 1'b1;
        end else if (apply_c) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div     <= RESET_DIV;
            high    <= RESET_HIGH;
            shadow  <= RESET_DIV;
            pending <= 1'b0;
            tick    <= 1'b0;
            level   <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            div     <= div_next;
            high    <= high_next;
            shadow  <= shadow_next;
            pending <= pending_next;
            tick    <= wrap_c && !restart;
            if (restart || run) begin
                level <= (cnt_next < high_next);
            end
        end
    end

endmodule

// File: rtl/timebase_generator.sv
// Cascaded single-clock timebase: CHANNELS divider stages producing tick strobes and duty levels.
module timebase_generator
    import timebase_pkg::*;
#(
    parameter int unsigned                      CHANNELS   = 3,
    parameter int unsigned                      CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter logic [CHANNELS*CNT_WIDTH-1:0]    DIVISORS   = {28'd1000, 28'd1000, 28'd50},
    parameter logic [CHANNELS*DUTY_W-1:0]       DUTY_CYCLE = {8'd50, 8'd80, 8'd50},
    localparam int unsigned                     SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Enable,
    input  logic                 Restart,
    input  logic                 DivLoad,
    input  logic [SEL_W-1:0]     DivSel,
    input  logic [CNT_WIDTH-1:0] DivValue,
    output logic [CHANNELS-1:0]  DivPending,
    output logic                 DivErr,
    output logic [CHANNELS-1:0]  Tick,
    output logic [CHANNELS-1:0]  Level
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic sel_ok_c;
    logic load_ok_c;

    assign sel_ok_c  = ({1'b0, DivSel} < CH_LIMIT);
    assign load_ok_c = DivLoad && sel_ok_c && (DivValue != '0);

    if (CNT_WIDTH > HC_W) begin : g_bad_width
        $error("timebase_generator: CNT_WIDTH exceeds supported width");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CNT_WIDTH-1:0] RST_DIV = DIVISORS[i*CNT_WIDTH +: CNT_WIDTH];
        localparam logic [DUTY_W-1:0]    DUTY    = DUTY_CYCLE[i*DUTY_W +: DUTY_W];

        if (RST_DIV == '0) begin : g_bad_div
            $error("timebase_generator: reset divisor of a channel is zero");
        end
        if ((DUTY < 8'd1) || (DUTY > 8'd99)) begin : g_bad_duty
            $error("timebase_generator: duty cycle outside 1..99");
        end

        logic in_tick;
        logic wrap_c;
        logic load;

        // Stage i is clocked by the same-cycle wrap of stage i-1.
        if (i == 0) begin : g_src_enable
            assign in_tick = Enable;
        end else begin : g_src_prev
            assign in_tick = g_ch[i-1].wrap_c;
        end

        assign load = load_ok_c && (DivSel == SEL_W'(i));

        timebase_stage #(
            .CNT_WIDTH (CNT_WIDTH),
            .RESET_DIV (RST_DIV),
            .DUTY      (DUTY)
        ) u_stage (
            .clk        (Clk),
            .rst_n      (Rst_n),
            .run        (Enable),
            .in_tick    (in_tick),
            .restart    (Restart),
            .load       (load),
            .load_value (DivValue),
            .wrap_c     (wrap_c),
            .tick       (Tick[i]),
            .level      (Level[i]),
            .pending    (DivPending[i])
        );
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            DivErr <= 1'b0;
        end else begin
            DivErr <= DivLoad && !(sel_ok_c && (DivValue != '0));
        end
    end

endmodule

// File: tb/tb_timebase_generator.sv
// Self-checking bench: directed scenarios plus random stimulus against a period-counting reference model.
module tb_timebase_generator;

    localparam int unsigned CH = 3;
    localparam int unsigned CW = 8;
    localparam logic [CH*CW-1:0] DIVS = {8'd4, 8'd3, 8'd2};
    localparam logic [CH*8-1:0]  DUTY = {8'd50, 8'd50, 8'd80};

    int duty_m[CH]  = '{80, 50, 50};
    int rst_div[CH] = '{2, 3, 4};

    logic          Clk      = 1'b0;
    logic          Rst_n    = 1'b0;
    logic          Enable   = 1'b0;
    logic          Restart  = 1'b0;
    logic          DivLoad  = 1'b0;
    logic [1:0]    DivSel   = '0;
    logic [CW-1:0] DivValue = '0;
    logic [CH-1:0] DivPending;
    logic          DivErr;
    logic [CH-1:0] Tick;
    logic [CH-1:0] Level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: inputs-seen-this-period per channel, divisors and duty thresholds as integers.
    int m_cnt[CH];
    int m_div[CH];
    int m_sh[CH];
    int m_hi[CH];
    bit m_pend[CH];
    bit m_tick[CH];
    bit m_lvl[CH];
    bit m_err;

    timebase_generator #(
        .CHANNELS   (CH),
        .CNT_WIDTH  (CW),
        .DIVISORS   (DIVS),
        .DUTY_CYCLE (DUTY)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Enable     (Enable),
        .Restart    (Restart),
        .DivLoad    (DivLoad),
        .DivSel     (DivSel),
        .DivValue   (DivValue),
        .DivPending (DivPending),
        .DivErr     (DivErr),
        .Tick       (Tick),
        .Level      (Level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int hi_of(input int d, input int duty);
        int h;
        if (d < 2) return 1;
        h = (d * duty) / 100;
        if (h < 1) h = 1;
        if (h > d - 1) h = d - 1;
        return h;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = rst_div[i];
            m_sh[i]   = rst_div[i];
            m_hi[i]   = hi_of(rst_div[i], duty_m[i]);
            m_pend[i] = 1'b0;
            m_tick[i] = 1'b0;
            m_lvl[i]  = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_step();
        bit in_t;
        bit done;
        bit use_new;
        m_err = DivLoad && ((int'(DivSel) >= CH) || (DivValue == 0));
        in_t  = Enable;
        for (int i = 0; i < CH; i++) begin
            done    = in_t && (m_cnt[i] + 1 == m_div[i]);
            use_new = m_pend[i] && (done || Restart);
            if (use_new) begin
                m_div[i] = m_sh[i];
                m_hi[i]  = hi_of(m_sh[i], duty_m[i]);
            end
            if (Restart || done) m_cnt[i] = 0;
            else if (in_t) m_cnt[i] = m_cnt[i] + 1;
            if (DivLoad && (int'(DivSel) == i) && (DivValue != 0)) begin
                m_sh[i]   = int'(DivValue);
                m_pend[i] = 1'b1;
            end else if (use_new) begin
                m_pend[i] = 1'b0;
            end
            m_tick[i] = done && !Restart;
            if (Restart || Enable) m_lvl[i] = (m_cnt[i] < m_hi[i]);
            in_t = done;
        end
    endfunction

    task automatic compare_all();
        logic [CH-1:0] et, el, ep;
        for (int i = 0; i < CH; i++) begin
            et[i] = m_tick[i];
            el[i] = m_lvl[i];
            ep[i] = m_pend[i];
        end
        check("tick",    32'(Tick),       32'(et));
        check("level",   32'(Level),      32'(el));
        check("pending", 32'(DivPending), 32'(ep));
        check("diverr",  32'(DivErr),     32'(m_err));
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic load(input int sel, input int val);
        DivLoad  = 1'b1;
        DivSel   = 2'(sel);
        DivValue = CW'(val);
        step();
        DivLoad  = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output int t);
        t = -1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (Tick[ch]) begin
                t = cyc;
                break;
            end
        end
        check("tick_timeout", 32'(t >= 0), 32'd1);
    endtask

    initial begin
        int n1, n2, hi_cnt, tk_cnt, t0, t1, t2;
        logic [CH-1:0] lv;

        model_reset();
        #12;
        check("rst_tick",    32'(Tick),       32'd0);
        check("rst_level",   32'(Level),      32'd0);
        check("rst_pending", 32'(DivPending), 32'd0);
        check("rst_diverr",  32'(DivErr),     32'd0);
        @(negedge Clk);
        Rst_n  = 1'b1;
        Enable = 1'b1;

        // Cascade 2/3/4: periods 2, 6, 24 with coincident ticks at the slow wrap.
        n1 = 0;
        n2 = 0;
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k == 2)  check("t1_first_tick0", 32'(Tick[0]), 32'd1);
            if (k == 24) check("t1_coincide", 32'(Tick), 32'd7);
            n1 += int'(Tick[1]);
            n2 += int'(Tick[2]);
        end
        check("t1_tick1_count", 32'(n1), 32'd8);
        check("t1_tick2_count", 32'(n2), 32'd2);

        // ch0 divisor 10 with 80% duty: 8 of every 10 cycles high.
        load(0, 10);
        check("t2_pending", 32'(DivPending[0]), 32'd1);
        repeat (12) step();
        hi_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi_cnt += int'(Level[0]);
        end
        check("t2_duty80", 32'(hi_cnt), 32'd8);
        load(0, 1);
        repeat (12) step();
        hi_cnt = 0;
        tk_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi_cnt += int'(Level[0]);
            tk_cnt += int'(Tick[0]);
        end
        check("t2_div1_level", 32'(hi_cnt), 32'd10);
        check("t2_div1_ticks", 32'(tk_cnt), 32'd10);
        load(0, 2);
        repeat (4) step();

        // Mid-period reload of ch1: current period keeps 6, next is 10.
        wait_tick(1, t0);
        step();
        step();
        load(1, 5);
        check("t3_pending_set", 32'(DivPending[1]), 32'd1);
        wait_tick(1, t1);
        check("t3_old_period", 32'(t1 - t0), 32'd6);
        check("t3_pending_clr", 32'(DivPending[1]), 32'd0);
        wait_tick(1, t2);
        check("t3_new_period", 32'(t2 - t1), 32'd10);

        // Rejected loads.
        load(1, 0);
        check("t4_err_zero", 32'(DivErr), 32'd1);
        check("t4_pend_zero", 32'(DivPending), 32'd0);
        step();
        check("t4_err_clear", 32'(DivErr), 32'd0);
        load(3, 7);
        check("t4_err_sel", 32'(DivErr), 32'd1);
        check("t4_pend_sel", 32'(DivPending), 32'd0);

        // Enable low for 7 cycles shifts the next tick by 7, Level frozen.
        wait_tick(0, t0);
        step();
        lv     = Level;
        Enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check("t5_level_hold", 32'(Level), 32'(lv));
            check("t5_no_tick", 32'(Tick), 32'd0);
        end
        Enable = 1'b1;
        wait_tick(0, t1);
        check("t5_shift", 32'(t1 - t0), 32'd9);

        // Restart on a wrap edge suppresses the tick.
        for (int k = 0; k < 50; k++) begin
            if (m_cnt[0] + 1 == m_div[0]) break;
            step();
        end
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        check("t6_restart_tick", 32'(Tick), 32'd0);
        check("t6_restart_level", 32'(Level), 32'd7);

        // Async reset mid-run drops outputs immediately and restores reset divisors.
        load(2, 9);
        repeat (3) step();
        #2;
        Rst_n = 1'b0;
        #1;
        check("t6_arst_tick",    32'(Tick),       32'd0);
        check("t6_arst_level",   32'(Level),      32'd0);
        check("t6_arst_pending", 32'(DivPending), 32'd0);
        check("t6_arst_diverr",  32'(DivErr),     32'd0);
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        step();
        check("t6_post_rst_tick0", 32'(Tick[0]), 32'd1);
        repeat (30) step();

        // Random traffic against the model.
        for (int k = 0; k < 2500; k++) begin
            Enable  = ($urandom_range(0, 9) != 0);
            Restart = ($urandom_range(0, 199) == 0);
            DivLoad = ($urandom_range(0, 19) == 0);
            DivSel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) DivValue = '0;
            else DivValue = CW'($urandom_range(1, 5));
            step();
        end
        Enable  = 1'b0;
        Restart = 1'b0;
        DivLoad = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
